// File: rtl/pipe_chain_pkg.sv
// rtl/pipe_chain_pkg.sv - shared defaults and stage record for the pipe_chain register chain
package pipe_chain_pkg;

  localparam int PC_WIDTH = 32;
  localparam int PC_DEPTH = 5;
  localparam int PC_CNT_W = 16;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] data;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, data: '0};

endpackage

// File: rtl/pipe_chain_stage.sv
// rtl/pipe_chain_stage.sv - one pipeline register with flush > hold > load/bubble priority
import pipe_chain_pkg::*;

module pipe_chain_stage #(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             hold_prev_i,
  input  logic             prev_valid_i,
  input  logic [WIDTH-1:0] prev_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             next_valid_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  // hold_prev_i is tied low for stage 0, so its "prev" is the chain input
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (hold_i) begin
      valid_d = valid_q;
      data_d  = data_q;
    end else if (hold_prev_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      valid_d = prev_valid_i;
      data_d  = prev_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign next_valid_o = valid_d;

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - DEPTH-stage payload chain with stall/flush; PIPE_CHAIN_STATS_EN adds stall/bubble counters
import pipe_chain_pkg::*;

module pipe_chain #(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH,
  parameter int CNT_W = PC_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   in_ready_o,
  input  logic [DEPTH-1:0]       stall_i,
  input  logic [DEPTH-1:0]       flush_i,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [DEPTH*WIDTH-1:0] stage_data_o,
  output logic                   out_valid_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [CNT_W-1:0]       occupancy_o
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles_o,
  output logic [CNT_W-1:0]       bubble_cycles_o
`endif
);

  logic [DEPTH:0]   hold;
  logic [DEPTH-1:0] next_valid;
  logic [CNT_W-1:0] occ_next;
  logic [CNT_W-1:0] occ_q;

  // A stall freezes its own stage and every younger one behind it
  always_comb begin
    hold        = '0;
    hold[DEPTH] = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hold[k] = stall_i[k] | hold[k+1];
    end
  end

  assign in_ready_o = ~hold[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;
    logic             hold_prev;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid_i;
      assign prev_data  = in_data_i;
      assign hold_prev  = 1'b0;
    end else begin : g_body
      assign prev_valid = stage_valid_o[k-1];
      assign prev_data  = stage_data_o[(k-1)*WIDTH +: WIDTH];
      assign hold_prev  = hold[k-1];
    end

    pipe_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i[k]),
      .hold_i       (hold[k]),
      .hold_prev_i  (hold_prev),
      .prev_valid_i (prev_valid),
      .prev_data_i  (prev_data),
      .valid_o      (stage_valid_o[k]),
      .data_o       (stage_data_o[k*WIDTH +: WIDTH]),
      .next_valid_o (next_valid[k])
    );
  end

  assign out_valid_o = stage_valid_o[DEPTH-1];
  assign out_data_o  = stage_data_o[(DEPTH-1)*WIDTH +: WIDTH];

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + CNT_W'(next_valid[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_next;
    end
  end

  assign occupancy_o = occ_q;

`ifdef PIPE_CHAIN_STATS_EN
  logic             bubble_any;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // A bubble is born at stage k when the stage behind it is held but k is free
  always_comb begin
    bubble_any = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      bubble_any = bubble_any | (hold[k-1] & ~hold[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if ((|stall_i) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bubble_any && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles_o  = stall_cnt_q;
  assign bubble_cycles_o = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised pipeline register chain with per-stage valid tracking, stall propagation, bubble insertion and per-stage flush. It generalises the fixed inter-stage pipe register of the 5-stage CPU into one configurable block. The block carries an opaque payload (decoded instruction, PC, control bits) through DEPTH stages and gives the CPU datapath a single place to implement load-use stalls and branch flushes.

## Interface
- WIDTH, 32, payload bits per stage (≥1)
- DEPTH, 5, number of register stages (≥1); stage 0 is youngest, stage DEPTH-1 is oldest
- CNT_W, 16, width of occupancy and statistics counters
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- in_valid_i  in  1  new entry offered to stage 0
- in_data_i  in  WIDTH  payload of new entry
- in_ready_o  out  1  stage 0 accepts this cycle (= ~hold[0])
- stall_i  in  DEPTH  bit k: stage k must keep its contents
- flush_i  in  DEPTH  bit k: stage k becomes a bubble at next edge
- stage_valid_o  out  DEPTH  registered valid of every stage
- stage_data_o  out  DEPTH*WIDTH  registered payload; stage k at [k*WIDTH +: WIDTH]
- out_valid_o  out  1  = stage_valid_o[DEPTH-1]
- out_data_o  out  WIDTH  payload of stage DEPTH-1
- occupancy_o  out  CNT_W  registered count of valid stages

## Operation
- hold[DEPTH] = 0; hold[k] = stall_i[k] | hold[k+1] (stall propagates to all younger stages).
- Next state of stage k, priority order: flush_i[k] -> bubble; hold[k] -> keep; k==0 -> {in_valid_i, in_data_i}; hold[k-1] -> bubble; else copy stage k-1.
- Bubble: valid = 0, data = 0 (deterministic, not don't-care).
- Stage 0 accepts when in_valid_i & in_ready_o; an offered entry with in_ready_o low is not captured and the source must hold it.
- Flush overrides stall on the same stage; flush does not alter hold propagation (stall_i[k] still freezes younger stages even if stage k is flushed).
- Oldest stage drains every cycle it is not held; no downstream handshake.
- occupancy_o = popcount of next-state valids, registered; range 0..DEPTH, no wrap.

## Timing
- Reset: all valids 0, all data 0, occupancy_o 0, statistics counters 0; in_ready_o is 1 in the first cycle after reset (stall_i permitting).
- Latency: entry accepted at edge n is at stage k after edge n+k, visible on out_* after edge n+DEPTH-1; throughput 1/cycle with no stalls.
- stall_i and flush_i sampled combinationally, effect at the next edge only.
- in_ready_o is combinational from stall_i (no register).
- Reset asserted mid-stream discards all contents in one edge regardless of stall_i/flush_i.

## Configuration
- PIPE_CHAIN_STATS_EN defined: adds stall_cycles_o (CNT_W, out) counting cycles with any stall_i bit set, and bubble_cycles_o (CNT_W, out) counting cycles where some k has hold[k-1] & ~hold[k]; both saturate at all-ones, reset to 0.
- Undefined: ports and counters absent; remaining behaviour identical.

## Structure
- Package pipe_chain_pkg: default WIDTH/DEPTH/CNT_W constants and a stage_t struct {valid, data} typedef.
- Sub-module pipe_chain_stage: one stage register implementing the flush/hold/load/bubble priority; top instantiates DEPTH copies in a generate loop plus hold chain, occupancy and statistics logic.

## Test plan
- DEPTH=5: push 0x11..0x15 on consecutive cycles, no stall -> out_data_o shows 0x11 four cycles after first accept, then 0x12..0x15 back-to-back; occupancy_o peaks at 5.
- Fill pipe, assert stall_i[2] for 2 cycles -> stages 0–2 frozen, in_ready_o = 0, stage 3 receives two bubbles (valid 0, data 0), stages 3–4 drain; bubble_cycles_o = 2 with macro.
- Fill pipe, pulse flush_i = 5'b00111 -> stages 0–2 invalid next cycle, occupancy_o drops from 5 to 2, stages 3–4 advance normally.
- Same cycle stall_i[1] and flush_i[1] -> stage 1 becomes bubble, stage 0 still held, in_ready_o = 0.
- Assert rst_i with pipe full and stall_i = all-ones -> all valids 0, occupancy_o 0, counters 0 after one edge.
- With macro, hold stall_i[0] for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cycles_o saturates at 15.
